// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt controller: width calculation,
// lowest-index priority encoder and the per-line state encoding.
package irq_pkg;

    localparam int unsigned MAX_IRQ = 32;
    localparam int unsigned IDX_W   = 5;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } prio_t;

    // Bit 1 = in service, bit 0 = pending.
    typedef enum logic [1:0] {
        LS_IDLE      = 2'b00,
        LS_PEND      = 2'b01,
        LS_SERV      = 2'b10,
        LS_PEND_SERV = 2'b11
    } line_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    function automatic prio_t prio_enc(input logic [MAX_IRQ-1:0] v);
        prio_t r;
        r = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int unsigned i = MAX_IRQ; i > 0; i--) begin
            if (v[i-1]) begin
                r.valid = 1'b1;
                r.idx   = IDX_W'(i - 1);
            end
        end
        return r;
    endfunction

    function automatic line_state_e line_state(input logic pend, input logic serv);
        return line_state_e'({serv, pend});
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous request line, followed by a
// history flop that turns the synchronised level into a one-cycle rising pulse.
module irq_sync_edge (
    input  logic Clock,
    input  logic Reset,
    input  logic line_i,
    output logic rise_o
);

    logic s1_q;
    logic s2_q;
    logic prev_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= line_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// N-source interrupt controller: edge capture, masking, fixed priority with
// nested in-service tracking, and the ack/eret handshake with the CPU.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned       N_IRQ    = 3,
    parameter int unsigned       ID_W     = clog2(N_IRQ),
    parameter logic [N_IRQ-1:0]  MASK_RST = '1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [N_IRQ-1:0] ir,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             int_ack,
    input  logic             eret,
    output logic             int_req,
    output logic [ID_W-1:0]  int_id,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] in_service,
    output logic [N_IRQ-1:0] overrun
);

    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] in_service_q, in_service_d;
    logic [N_IRQ-1:0] overrun_q, overrun_d;
    logic [N_IRQ-1:0] mask_q, mask_d;

    logic [N_IRQ-1:0] elig;
    logic [N_IRQ-1:0] below_cur;
    logic [N_IRQ-1:0] req_vec;
    logic [N_IRQ-1:0] ack_vec;
    logic [N_IRQ-1:0] eret_vec;
    prio_t            cur;
    prio_t            win;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_line
        irq_sync_edge u_sync (
            .Clock  (Clock),
            .Reset  (Reset),
            .line_i (ir[g]),
            .rise_o (rise[g])
        );
    end

    // Only lines strictly above the current handler's priority may preempt it.
    always_comb begin
        elig      = pending_q & mask_q;
        cur       = prio_enc(MAX_IRQ'(in_service_q));
        below_cur = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            below_cur[i] = !cur.valid || (i < 32'(cur.idx));
        end
        req_vec = elig & below_cur;
        win     = prio_enc(MAX_IRQ'(req_vec));
    end

    assign int_req = win.valid;
    assign int_id  = ID_W'(win.idx);

    always_comb begin
        ack_vec  = '0;
        eret_vec = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            ack_vec[i]  = int_ack && win.valid && (32'(win.idx) == i);
            eret_vec[i] = eret && cur.valid && (32'(cur.idx) == i);
        end
        // A fresh edge on the line being acked re-arms it rather than overrunning.
        pending_d    = (pending_q & ~ack_vec) | rise;
        overrun_d    = overrun_q | (rise & pending_q & ~ack_vec);
        in_service_d = (in_service_q & ~eret_vec) | ack_vec;
        mask_d       = mask_we ? mask_wdata : mask_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pending_q    <= '0;
            in_service_q <= '0;
            overrun_q    <= '0;
            mask_q       <= MASK_RST;
        end else begin
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            overrun_q    <= overrun_d;
            mask_q       <= mask_d;
        end
    end

    // The acked line can never already be in service: it outranks the current handler.
    for (genvar g = 0; g < N_IRQ; g++) begin : g_chk
        always_ff @(posedge Clock) begin
            if (!Reset && ack_vec[g]) begin
                assert (line_state(pending_q[g], in_service_q[g]) == LS_PEND);
            end
        end
    end

    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_irq_ctrl;

    localparam int unsigned N = 3;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic [N-1:0] ir = '0;
    logic         mask_we = 1'b0;
    logic [N-1:0] mask_wdata = '0;
    logic         int_ack = 1'b0;
    logic         eret = 1'b0;
    logic         int_req;
    logic [1:0]   int_id;
    logic [N-1:0] pending;
    logic [N-1:0] in_service;
    logic [N-1:0] overrun;

    always #5 Clock = ~Clock;

    irq_ctrl #(.N_IRQ(N)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .ir         (ir),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .eret       (eret),
        .int_req    (int_req),
        .int_id     (int_id),
        .pending    (pending),
        .in_service (in_service),
        .overrun    (overrun)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_serv = '0;
    logic [N-1:0] m_ovr  = '0;
    logic [N-1:0] m_mask = '1;
    // seen[k] = ir level observed k+1 clock edges ago (0 while in reset)
    logic [N-1:0] seen [3] = '{default: '0};

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int m_winner();
        int c;
        c = lowest(m_serv);
        for (int i = 0; i < N; i++)
            if (m_pend[i] && m_mask[i] && (c < 0 || i < c)) return i;
        return -1;
    endfunction

    always @(posedge Clock) begin
        int w, c;
        logic [N-1:0] rise, old_pend;
        if (Reset) begin
            m_pend = '0; m_serv = '0; m_ovr = '0; m_mask = '1;
            seen[0] = '0; seen[1] = '0; seen[2] = '0;
        end else begin
            w = m_winner();
            c = lowest(m_serv);
            // synchronised level two edges back, previous level three edges back
            rise = seen[1] & ~seen[2];
            old_pend = m_pend;
            for (int i = 0; i < N; i++) begin
                if (eret && i == c) m_serv[i] = 1'b0;
                if (int_ack && i == w) begin
                    m_pend[i] = 1'b0;
                    m_serv[i] = 1'b1;
                end
                if (rise[i]) begin
                    if (old_pend[i] && !(int_ack && i == w)) m_ovr[i] = 1'b1;
                    m_pend[i] = 1'b1;
                end
            end
            if (mask_we) m_mask = mask_wdata;
            seen[2] = seen[1];
            seen[1] = seen[0];
            seen[0] = ir;
        end
    end

    always @(negedge Clock) begin
        int w;
        w = m_winner();
        chk("model_int_req",    32'(int_req),    32'(w >= 0));
        chk("model_int_id",     32'(int_id),     (w >= 0) ? 32'(w) : 32'd0);
        chk("model_pending",    32'(pending),    32'(m_pend));
        chk("model_in_service", 32'(in_service), 32'(m_serv));
        chk("model_overrun",    32'(overrun),    32'(m_ovr));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clock);
        #2;
    endtask

    task automatic pulse(input logic [N-1:0] m);
        ir = m; tick(1); ir = '0; tick(2);
    endtask

    task automatic ack();
        int_ack = 1'b1; tick(1); int_ack = 1'b0;
    endtask

    task automatic ret();
        eret = 1'b1; tick(1); eret = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; tick(3); Reset = 1'b0; tick(1);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_int_req", 32'(int_req), 32'd0);

        // single request, latency, ack, return
        ir = 3'b001; tick(1); ir = '0; tick(1);
        chk("t1_pend_e2", 32'(pending), 32'd0);
        tick(1);
        chk("t1_pend_e3", 32'(pending), 32'b001);
        chk("t1_req_e3",  32'(int_req), 32'd1);
        chk("t1_id_e3",   32'(int_id),  32'd0);
        ack();
        chk("t1_serv", 32'(in_service), 32'b001);
        chk("t1_req_after_ack", 32'(int_req), 32'd0);
        ret();
        chk("t1_serv_after_eret", 32'(in_service), 32'd0);

        // nesting
        pulse(3'b100);
        chk("t2_id2", 32'(int_id), 32'd2);
        ack();
        chk("t2_serv100", 32'(in_service), 32'b100);
        pulse(3'b010);
        chk("t2_nest_req", 32'(int_req), 32'd1);
        chk("t2_nest_id",  32'(int_id),  32'd1);
        ack();
        chk("t2_serv110", 32'(in_service), 32'b110);
        ret();
        chk("t2_eret1", 32'(in_service), 32'b100);
        ret();
        chk("t2_eret2", 32'(in_service), 32'b000);

        // lower priority blocked until return
        pulse(3'b010); ack();
        chk("t3_serv010", 32'(in_service), 32'b010);
        pulse(3'b100);
        chk("t3_blocked", 32'(int_req), 32'd0);
        chk("t3_pend100", 32'(pending), 32'b100);
        ret();
        chk("t3_req_after_eret", 32'(int_req), 32'd1);
        chk("t3_id_after_eret",  32'(int_id),  32'd2);
        ack(); ret();

        // masking
        pulse(3'b001);
        mask_we = 1'b1; mask_wdata = 3'b110; tick(1); mask_we = 1'b0;
        chk("t4_masked_req",  32'(int_req), 32'd0);
        chk("t4_masked_pend", 32'(pending), 32'b001);
        mask_we = 1'b1; mask_wdata = 3'b111; tick(1); mask_we = 1'b0;
        chk("t4_unmask_req", 32'(int_req), 32'd1);
        ack(); ret();

        // overrun and ack colliding with a new edge
        pulse(3'b010); pulse(3'b010);
        chk("t5_overrun", 32'(overrun), 32'b010);
        chk("t5_pend",    32'(pending), 32'b010);
        ir = 3'b010; tick(1); ir = '0; tick(1);
        ack();
        chk("t5_pend_kept", 32'(pending),    32'b010);
        chk("t5_serv",      32'(in_service), 32'b010);
        ret(); ack();
        pulse(3'b001); ack();
        chk("t6_serv011", 32'(in_service), 32'b011);

        // reset mid-handler with a line held high
        ir = 3'b100; Reset = 1'b1; tick(1);
        chk("t6_rst_pend", 32'(pending),    32'd0);
        chk("t6_rst_serv", 32'(in_service), 32'd0);
        chk("t6_rst_ovr",  32'(overrun),    32'd0);
        chk("t6_rst_req",  32'(int_req),    32'd0);
        chk("t6_rst_id",   32'(int_id),     32'd0);
        tick(2); Reset = 1'b0; tick(2);
        chk("t6_pend_r2", 32'(pending), 32'd0);
        tick(1);
        chk("t6_pend_r3", 32'(pending), 32'b100);
        chk("t6_id_r3",   32'(int_id),  32'd2);
        tick(3);
        chk("t6_single_edge", 32'(overrun), 32'd0);
        ir = '0; ack(); ret();

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            ir         = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
            int_ack    = ($urandom_range(0, 2) == 0);
            eret       = ($urandom_range(0, 3) == 0);
            mask_we    = ($urandom_range(0, 19) == 0);
            mask_wdata = 3'($urandom_range(0, 7));
            Reset      = ($urandom_range(0, 199) == 0);
            tick(1);
        end
        ir = '0; int_ack = 1'b0; eret = 1'b0; mask_we = 1'b0; Reset = 1'b0;
        tick(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
